div: RTL and testbench



---
 rtl/div_if.sv | 23 ++
 rtl/div.sv | 123 ++++++++++++
 tb/tb_div.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// rtl/div_if.sv - execute-stage handshake and operand bus for the divider
interface div_if;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [2:0]  op_i;
  logic [4:0]  reg_waddr_i;
  logic        start_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  modport master (
    output dividend_i, divisor_i, op_i, reg_waddr_i, start_i, flush_i,
    input  result_o, ready_o, busy_o, reg_waddr_o
  );

  modport slave (
    input  dividend_i, divisor_i, op_i, reg_waddr_i, start_i, flush_i,
    output result_o, ready_o, busy_o, reg_waddr_o
  );
endinterface

// File: rtl/div.sv
// rtl/div.sv - multi-cycle RV32M divider, restoring shift-subtract core with sign wrap
module div (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  state_t      state;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic        is_rem;
  logic        is_unsigned;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] result_q;
  logic        ready_q;
  logic        busy_q;
  logic [4:0]  waddr_q;

  logic [32:0] part;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  function automatic logic [31:0] mag(input logic [31:0] x);
    mag = x[31] ? (~x + 32'd1) : x;
  endfunction

  always_comb begin
    part  = {rem, dvd[31]};
    diff  = part - {1'b0, dvs};
    q_fix = neg_q ? (~quo + 32'd1) : quo;
    r_fix = neg_r ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      is_rem      <= 1'b0;
      is_unsigned <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result_q    <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      waddr_q     <= '0;
    end else if (bus.flush_i) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i && bus.op_i[2]) begin
            dvd         <= bus.dividend_i;
            dvs         <= bus.divisor_i;
            is_rem      <= bus.op_i[1];
            is_unsigned <= bus.op_i[0];
            waddr_q     <= bus.reg_waddr_i;
            busy_q      <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          cnt <= '0;
          if (dvs == 32'd0) begin
            // Special results bypass the core and the sign fix-up.
            quo   <= 32'hFFFF_FFFF;
            rem   <= dvd;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= S_END;
          end else begin
            quo   <= '0;
            rem   <= '0;
            neg_q <= ~is_unsigned & (dvd[31] ^ dvs[31]);
            neg_r <= ~is_unsigned & dvd[31];
            if (!is_unsigned) begin
              dvd <= mag(dvd);
              dvs <= mag(dvs);
            end
            state <= S_CALC;
          end
        end
        S_CALC: begin
          // rem < dvs always holds, so the difference fits in 32 bits.
          if (part >= {1'b0, dvs}) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= part[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          dvd <= {dvd[30:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_END;
        end
        S_END: begin
          result_q <= is_rem ? r_fix : q_fix;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.reg_waddr_o = waddr_q;
endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed-vector bench for the divider
module tb_div;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   lat;
  int   bcnt;

  div_if bus();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa);
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = wa;
    bus.start_i     = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i     = 1'b0;
  endtask

  // lat = edges after the accept edge until ready_o is seen (0 on timeout)
  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) begin
        l = k;
        break;
      end
      if (bus.busy_o) b++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa,
                       input logic [31:0] exp, input int lat_exp);
    int l;
    int bc;
    @(negedge clk);
    launch(op, a, b, wa);
    wait_done(l, bc);
    check({tag, "_lat"}, l, lat_exp);
    check({tag, "_busy"}, bc, lat_exp - 1);
    check({tag, "_res"}, bus.result_o, exp);
    check({tag, "_waddr"}, bus.reg_waddr_o, {27'd0, wa});
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, bus.ready_o, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.dividend_i = '0;
    bus.divisor_i = '0;
    bus.op_i = '0;
    bus.reg_waddr_i = '0;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_res", bus.result_o, 32'd0);
    check("rst_ready", bus.ready_o, 32'd0);
    check("rst_busy", bus.busy_o, 32'd0);
    check("rst_waddr", bus.reg_waddr_o, 32'd0);

    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd6, 32'd2, 34);
    do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34);
    do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34);
    do_op("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 34);
    do_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, 34);
    do_op("divu_5_0", 3'b101, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 2);
    do_op("rem_m7_0", 3'b110, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFF9, 2);

    // flush at N+10 with a competing start in the same cycle
    @(negedge clk);
    launch(3'b101, 32'd1000, 32'd3, 5'd9);
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    bus.start_i = 1'b1;
    bus.reg_waddr_i = 5'd12;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    check("flush_busy", bus.busy_o, 32'd0);
    check("flush_ready", bus.ready_o, 32'd0);
    wait_done(lat, bcnt);
    check("flush_no_ready", lat, 32'd0);
    check("flush_no_busy", bcnt, 32'd0);
    check("flush_res_kept", bus.result_o, 32'hFFFF_FFF9);
    check("flush_waddr_kept", bus.reg_waddr_o, 32'd9);
    do_op("after_flush", 3'b101, 32'd1000, 32'd3, 5'd12, 32'd333, 34);

    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 34);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 34);

    // start held high and operands changed after acceptance
    @(negedge clk);
    bus.op_i = 3'b101;
    bus.dividend_i = 32'd200;
    bus.divisor_i = 32'd9;
    bus.reg_waddr_i = 5'd3;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.dividend_i = 32'd5;
    wait_done(lat, bcnt);
    bus.start_i = 1'b0;
    check("hold_lat", lat, 32'd34);
    check("hold_res", bus.result_o, 32'd22);

    // back-to-back: new start issued in the ready cycle
    @(posedge clk);
    @(negedge clk);
    launch(3'b101, 32'd50, 32'd5, 5'd4);
    wait_done(lat, bcnt);
    check("b2b_first_res", bus.result_o, 32'd10);
    launch(3'b111, 32'd50, 32'd6, 5'd6);
    check("b2b_pulse", bus.ready_o, 32'd0);
    check("b2b_busy", bus.busy_o, 32'd1);
    wait_done(lat, bcnt);
    check("b2b_lat", lat, 32'd34);
    check("b2b_res", bus.result_o, 32'd2);
    check("b2b_waddr", bus.reg_waddr_o, 32'd6);

    // asynchronous reset mid-operation
    @(posedge clk);
    @(negedge clk);
    launch(3'b101, 32'd77, 32'd7, 5'd15);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy_o, 32'd0);
    check("arst_ready", bus.ready_o, 32'd0);
    check("arst_res", bus.result_o, 32'd0);
    check("arst_waddr", bus.reg_waddr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(lat, bcnt);
    check("arst_no_ready", lat, 32'd0);

    // non-divide funct3 is ignored
    @(negedge clk);
    launch(3'b000, 32'd9, 32'd3, 5'd7);
    check("op000_busy", bus.busy_o, 32'd0);
    wait_done(lat, bcnt);
    check("op000_no_ready", lat, 32'd0);
    check("op000_waddr", bus.reg_waddr_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
